// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: any depth >= 2, occupancy count, almost-full/empty flags.
// Optional sticky ovf/udf error flags are compiled in with `define FIFO_ERR_FLAGS_EN.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 10,
  parameter int AFULL_TH  = 8,
  parameter int AEMPTY_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [DATA_W-1:0]            din,
  input  logic                         rd,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic                         afull,
  output logic                         aempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         ovf,
  output logic                         udf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrptr_q, wrptr_d;
  logic [AW-1:0]     rdptr_q, rdptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q;
  logic              rd_ok, wr_ok;

  // Explicit wrap so non-power-of-two depths never address past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_ok   = rd && !empty;
    wr_ok   = wr && (!full || rd_ok);
    wrptr_d = wr_ok ? ptr_inc(wrptr_q) : wrptr_q;
    rdptr_d = rd_ok ? ptr_inc(rdptr_q) : rdptr_q;
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wrptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      if (rd_ok) begin
        dout_q <= mem_q[rdptr_q];
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr && full && !rd_ok) ovf_q <= 1'b1;
      if (rd && empty)          udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

  // All status flags derive from the one count register, so they cannot disagree.
  assign count  = count_q;
  assign dout   = dout_q;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign afull  = (count_q >= CW'(AFULL_TH));
  assign aempty = (count_q <= CW'(AEMPTY_TH));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DATA_W=8, DEPTH=10, AFULL_TH=8, AEMPTY_TH=2.
// Error-flag checks are included when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       rd;
  logic [7:0] dout;
  logic       full, empty, afull, aempty;
  logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf, udf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(10), .AFULL_TH(8), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .full(full), .empty(empty), .afull(afull),
    .aempty(aempty), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr  = w;
    din = d;
    rd  = r;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int n);
    chk({tag, " count"},  int'(count),  n);
    chk({tag, " empty"},  int'(empty),  int'(n == 0));
    chk({tag, " full"},   int'(full),   int'(n == 10));
    chk({tag, " afull"},  int'(afull),  int'(n >= 8));
    chk({tag, " aempty"}, int'(aempty), int'(n <= 2));
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    #12;
    chk_state("reset", 0);
    chk("reset dout", int'(dout), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("reset ovf", int'(ovf), 0);
    chk("reset udf", int'(udf), 0);
`endif
    rst = 1'b0;

    // Fill 0x01..0x0A and drain, stepping every threshold on the way.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk_state($sformatf("fill%0d", i), i);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d dout", i), int'(dout), i);
      chk_state($sformatf("drain%0d", i), 10 - i);
    end

    // Wrap-around: offset pointers by 7, then pass 10 words across the 9->0 wrap.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("pre%0d dout", i), int'(dout), 8'h20 + i);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("wrap full", int'(full), 1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap%0d dout", i), int'(dout), 8'h10 + i);
    end
    chk("wrap empty", int'(empty), 1);

    // Full boundary: dropped write, then accepted write with simultaneous read.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk_state("wr on full", 10);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf set", int'(ovf), 1);
    chk("udf clear", int'(udf), 0);
`endif
    step(1'b1, 8'hBB, 1'b1);
    chk("wr+rd full count", int'(count), 10);
    chk("wr+rd full dout", int'(dout), 8'h30);
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("full drain%0d dout", i), int'(dout), 8'h30 + i);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("last dout", int'(dout), 8'hBB);
    chk_state("after full drain", 0);

    // Empty boundary: write accepted, read ignored, dout holds.
    step(1'b1, 8'h55, 1'b1);
    chk_state("wr+rd empty", 1);
    chk("wr+rd empty dout", int'(dout), 8'hBB);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf set", int'(udf), 1);
`endif
    step(1'b0, 8'h00, 1'b1);
    chk("read 0x55", int'(dout), 8'h55);
    chk("empty again", int'(empty), 1);

    // Asynchronous reset mid-operation at count=5 with rd active.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre-rst count", int'(count), 5);
    rd = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_state("async rst", 0);
    chk("async rst dout", int'(dout), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("async rst ovf", int'(ovf), 0);
    chk("async rst udf", int'(udf), 0);
`endif
    rd = 1'b0;
    #7;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h77, 1'b0);
    chk("post-rst count", int'(count), 1);
    chk("post-rst dout hold", int'(dout), 0);
    step(1'b0, 8'h00, 1'b1);
    chk("post-rst read", int'(dout), 8'h77);
    chk_state("post-rst end", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's 8-bit, 10-entry FIFO. Generalises data width and depth (including non-power-of-two depths), adds an occupancy count, programmable almost-full/almost-empty flags and true simultaneous read/write at the full and empty boundaries. Sits between producer and consumer blocks in the same clock domain as a general buffering primitive.

## Interface

Parameters:
- DATA_W, 8: data word width in bits, 1 or more.
- DEPTH, 10: number of storage entries, 2 or more, any integer.
- AFULL_TH, 8: afull asserts when count >= AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 2: aempty asserts when count <= AEMPTY_TH; range 0..DEPTH-1.
- Derived, not overridable: AW = $clog2(DEPTH) pointer width; CW = $clog2(DEPTH+1) count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- din  in  DATA_W  write data, sampled on the clk edge with wr.
- rd  in  1  read request.
- dout  out  DATA_W  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- afull  out  1  count >= AFULL_TH.
- aempty  out  1  count <= AEMPTY_TH.
- count  out  CW  current occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag (FIFO_ERR_FLAGS_EN only).
- udf  out  1  sticky underflow flag (FIFO_ERR_FLAGS_EN only).

## Operation

- Storage: DEPTH x DATA_W array, not reset; contents are only defined once written.
- Pointers wrptr and rdptr are AW bits, reset to 0, and increment modulo DEPTH: at DEPTH-1 they wrap to 0. They never address an index >= DEPTH.
- Accept rules, evaluated on the same edge from the pre-edge state:
  - rd_ok = rd && !empty.
  - wr_ok = wr && (!full || rd_ok). A write into a full FIFO is accepted when a read is accepted in the same cycle.
  - On empty, wr plus rd gives: write accepted, read ignored. No fall-through.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Count stays within 0..DEPTH.
- dout loads mem[rdptr] on rd_ok and holds its value otherwise.
- Flags are decoded combinationally from the registered count. There is no separate state register, so flags and count can never disagree.
- Rejected requests (wr on full without rd_ok, rd on empty) leave the storage array, pointers, count and dout unchanged.

## Timing

- Reset, asynchronous, any time including mid-transfer:
  - wrptr, rdptr, count = 0.
  - dout = 0.
  - empty = 1, full = 0, aempty = 1, afull = 0, ovf = udf = 0.
  - Stored data is lost logically; the array itself is not cleared.
- Write latency: word written at edge N is readable with rd at edge N+1. empty deasserts after edge N.
- Read latency: with rd asserted before edge N, dout is valid after edge N and holds until the next rd_ok.
- Flag updates appear after the same edge as the count change. Threshold crossing is exact at the boundary: count == AFULL_TH asserts afull.
- Sustained wr+rd at any occupancy from 1 to DEPTH gives one word per clock with count constant.

## Configuration

- FIFO_ERR_FLAGS_EN defined:
  - ovf and udf ports exist and are registered.
  - ovf sets on any edge with wr && full && !rd_ok.
  - udf sets on any edge with rd && empty.
  - Both are sticky and are cleared only by rst.
- FIFO_ERR_FLAGS_EN undefined:
  - ovf and udf ports and logic are absent.
  - Rejected requests are silently dropped as described above.

## Test plan

- Reset then fill, DATA_W=8, DEPTH=10: write 0x01..0x0A on 10 cycles, then read 10 times. Required response: dout reads 0x01..0x0A in order, full after the 10th write, empty after the 10th read, count returns to 0.
- Wrap-around: write 7, read 7, then write 10 and read 10 with data 0x10..0x19. Required response: order preserved across the pointer wrap from 9 to 0, no corruption.
- Full boundary: at count=10, assert wr with din=0xAA and no rd. Required response: count stays 10, data dropped, ovf=1 when the macro is defined. Then assert wr with din=0xBB and rd together. Required response: count stays 10, oldest word appears on dout, 0xBB is the last word read out.
- Empty boundary: at count=0, assert wr with din=0x55 and rd together. Required response: count=1, dout unchanged, udf=1 when the macro is defined. The next rd returns 0x55.
- Thresholds with AFULL_TH=8, AEMPTY_TH=2: step count 0 to 10 and back. Required response: aempty is 1 for count<=2, afull is 1 for count>=8, transitions occur exactly at 3/2 and 7/8.
- Reset mid-operation: at count=5 with rd active, assert rst between clock edges. Required response: all outputs at reset values immediately, before the next edge. After release, the first write then read returns the new data.
